// File: rtl/reg_rd.sv
// ---------------------------------------------------------------------------
// reg_rd : operand-read stage of the cpu15 pipeline.
//
// Reads two source operands out of the 8 x DATA_W register file (presented
// as the REG_0..REG_7 buses), forwards a same-cycle write-back value, and
// keeps an 8-bit scoreboard of destination writes that have been issued but
// not yet retired by the write-back stage. Instructions whose A/destination
// or B register has a write in flight are stalled. The selected operands
// and the decoded instruction fields are registered and handed to the
// execute stage over a valid/ready handshake.
//
// Ports:
//   CLK_RD       stage clock, shared with the write-back stage
//   RESET        synchronous active-high reset
//   INSN_VALID   upstream instruction valid
//   INSN_READY   stage accepts an instruction this cycle
//   INSN         [15:11] opcode, [10:8] N_A/dest, [7:5] N_B, [7:0] imm8
//   INSN_WR      instruction writes register INSN[10:8]
//   REG_0..REG_7 current register file contents
//   WB_N_REG     write-back target register
//   WB_REG_IN    write-back data
//   WB_REG_WEN   write-back enable; also retires the scoreboard bit
//   OP_VALID     operand bundle valid
//   OP_READY     execute stage accepts the bundle
//   OP_A / OP_B  operand values of INSN[10:8] / INSN[7:5]
//   OP_CODE      latched opcode
//   OP_IMM       latched imm8
//   OP_N_DST     latched destination register number
//   OP_WR        latched INSN_WR
//   SB_PEND      scoreboard, bit n = write to register n in flight
// ---------------------------------------------------------------------------
module reg_rd #(
  parameter int DATA_W = 16,
  parameter bit SB_EN  = 1'b1
) (
  input  logic              CLK_RD,
  input  logic              RESET,
  input  logic              INSN_VALID,
  output logic              INSN_READY,
  input  logic [15:0]       INSN,
  input  logic              INSN_WR,
  input  logic [DATA_W-1:0] REG_0,
  input  logic [DATA_W-1:0] REG_1,
  input  logic [DATA_W-1:0] REG_2,
  input  logic [DATA_W-1:0] REG_3,
  input  logic [DATA_W-1:0] REG_4,
  input  logic [DATA_W-1:0] REG_5,
  input  logic [DATA_W-1:0] REG_6,
  input  logic [DATA_W-1:0] REG_7,
  input  logic [2:0]        WB_N_REG,
  input  logic [DATA_W-1:0] WB_REG_IN,
  input  logic              WB_REG_WEN,
  output logic              OP_VALID,
  input  logic              OP_READY,
  output logic [DATA_W-1:0] OP_A,
  output logic [DATA_W-1:0] OP_B,
  output logic [4:0]        OP_CODE,
  output logic [7:0]        OP_IMM,
  output logic [2:0]        OP_N_DST,
  output logic              OP_WR,
  output logic [7:0]        SB_PEND
);

  // 3-to-8 one-hot decode of a register number.
  function automatic logic [7:0] dec3(input logic [2:0] n);
    logic [7:0] oh;
    case (n)
      3'd0:    oh = 8'b0000_0001;
      3'd1:    oh = 8'b0000_0010;
      3'd2:    oh = 8'b0000_0100;
      3'd3:    oh = 8'b0000_1000;
      3'd4:    oh = 8'b0001_0000;
      3'd5:    oh = 8'b0010_0000;
      3'd6:    oh = 8'b0100_0000;
      3'd7:    oh = 8'b1000_0000;
      default: oh = 8'b0000_0000;
    endcase
    return oh;
  endfunction

  // Instruction field decode
  logic [4:0]        code_s;
  logic [2:0]        n_a_s;
  logic [2:0]        n_b_s;
  logic [7:0]        imm_s;

  // Register file view and operand selection
  logic [DATA_W-1:0] reg_bus_s [8];
  logic [DATA_W-1:0] src_a_s;
  logic [DATA_W-1:0] src_b_s;

  // Scoreboard / handshake
  logic [7:0]        clr_s;
  logic [7:0]        pend_eff_s;
  logic [7:0]        set_s;
  logic [7:0]        sb_next_s;
  logic              haz_s;
  logic              insn_ready_s;
  logic              accept_s;

  // Pipeline registers
  logic              op_valid_r;
  logic [DATA_W-1:0] op_a_r;
  logic [DATA_W-1:0] op_b_r;
  logic [4:0]        op_code_r;
  logic [7:0]        op_imm_r;
  logic [2:0]        op_n_dst_r;
  logic              op_wr_r;
  logic [7:0]        sb_pend_r;

  assign code_s = INSN[15:11];
  assign n_a_s  = INSN[10:8];
  assign n_b_s  = INSN[7:5];
  assign imm_s  = INSN[7:0];

  assign reg_bus_s[0] = REG_0;
  assign reg_bus_s[1] = REG_1;
  assign reg_bus_s[2] = REG_2;
  assign reg_bus_s[3] = REG_3;
  assign reg_bus_s[4] = REG_4;
  assign reg_bus_s[5] = REG_5;
  assign reg_bus_s[6] = REG_6;
  assign reg_bus_s[7] = REG_7;

  // Operand A select: a write-back landing this cycle beats the stale bus value.
  always_comb begin
    src_a_s = reg_bus_s[n_a_s];
    if (WB_REG_WEN && (WB_N_REG == n_a_s)) begin
      src_a_s = WB_REG_IN;
    end else begin
      src_a_s = reg_bus_s[n_a_s];
    end
  end

  // Operand B select: same forwarding rule as operand A.
  always_comb begin
    src_b_s = reg_bus_s[n_b_s];
    if (WB_REG_WEN && (WB_N_REG == n_b_s)) begin
      src_b_s = WB_REG_IN;
    end else begin
      src_b_s = reg_bus_s[n_b_s];
    end
  end

  // Hazard detect: a bit retiring this cycle is no longer a hazard because
  // its value is forwarded. Checking N_A covers both RAW on A and WAW on
  // the destination.
  always_comb begin
    clr_s      = 8'h00;
    pend_eff_s = 8'h00;
    haz_s      = 1'b0;
    if (WB_REG_WEN) begin
      clr_s = dec3(WB_N_REG);
    end else begin
      clr_s = 8'h00;
    end
    pend_eff_s = sb_pend_r & ~clr_s;
    if (SB_EN) begin
      haz_s = pend_eff_s[n_a_s] | pend_eff_s[n_b_s];
    end else begin
      haz_s = 1'b0;
    end
  end

  // Handshake: ready does not look at INSN_VALID so upstream may wait on it.
  always_comb begin
    insn_ready_s = ~RESET & ~haz_s & (~op_valid_r | OP_READY);
    accept_s     = INSN_VALID & insn_ready_s;
  end

  // Scoreboard next state: OR-ing set after the clear lets a same-cycle
  // issue to a retiring register keep its bit.
  always_comb begin
    set_s     = 8'h00;
    sb_next_s = 8'h00;
    if (accept_s && INSN_WR) begin
      set_s = dec3(n_a_s);
    end else begin
      set_s = 8'h00;
    end
    sb_next_s = (sb_pend_r & ~clr_s) | set_s;
  end

  // Scoreboard register.
  always_ff @(posedge CLK_RD) begin
    if (RESET) begin
      sb_pend_r <= 8'h00;
    end else begin
      sb_pend_r <= sb_next_s;
    end
  end

  // Operand bundle register: loads on accept, drops valid when consumed,
  // otherwise holds every field stable.
  always_ff @(posedge CLK_RD) begin
    if (RESET) begin
      op_valid_r <= 1'b0;
      op_a_r     <= {DATA_W{1'b0}};
      op_b_r     <= {DATA_W{1'b0}};
      op_code_r  <= 5'd0;
      op_imm_r   <= 8'h00;
      op_n_dst_r <= 3'd0;
      op_wr_r    <= 1'b0;
    end else if (accept_s) begin
      op_valid_r <= 1'b1;
      op_a_r     <= src_a_s;
      op_b_r     <= src_b_s;
      op_code_r  <= code_s;
      op_imm_r   <= imm_s;
      op_n_dst_r <= n_a_s;
      op_wr_r    <= INSN_WR;
    end else if (op_valid_r && OP_READY) begin
      op_valid_r <= 1'b0;
    end else begin
      op_valid_r <= op_valid_r;
    end
  end

  assign INSN_READY = insn_ready_s;
  assign OP_VALID   = op_valid_r;
  assign OP_A       = op_a_r;
  assign OP_B       = op_b_r;
  assign OP_CODE    = op_code_r;
  assign OP_IMM     = op_imm_r;
  assign OP_N_DST   = op_n_dst_r;
  assign OP_WR      = op_wr_r;
  assign SB_PEND    = sb_pend_r;

endmodule

// File: doc/reg_rd.md
Name: reg_rd

Overview:
- Operand-read stage of the cpu15 pipeline; the read side of the 8 x 16-bit register file that the write-back stage updates.
- Accepts one instruction word per handshake and selects two source registers from the REG_0..REG_7 buses.
- Forwards a same-cycle write-back value and tracks in-flight destination writes with an 8-bit scoreboard, stalling on hazards.
- Presents registered operands to the execute stage over a valid/ready handshake.

Parameters:
DATA_W, 16, register/operand width
SB_EN, 1, 1 = scoreboard hazard stalls enabled; 0 = scoreboard never stalls (pending bits still tracked)

Ports:
CLK_RD  in  1  stage clock; shared with the write-back stage
RESET  in  1  synchronous, active-high reset
INSN_VALID  in  1  upstream instruction valid
INSN_READY  out  1  stage accepts instruction this cycle
INSN  in  16  [15:11] opcode, [10:8] N_A/dest, [7:5] N_B, [7:0] imm8
INSN_WR  in  1  instruction will write register INSN[10:8]
REG_0..REG_7  in  DATA_W each  current register file contents
WB_N_REG  in  3  write-back target register
WB_REG_IN  in  DATA_W  write-back data
WB_REG_WEN  in  1  write-back enable; also retires the scoreboard bit
OP_VALID  out  1  operand bundle valid
OP_READY  in  1  execute stage accepts bundle
OP_A  out  DATA_W  value of register INSN[10:8]
OP_B  out  DATA_W  value of register INSN[7:5]
OP_CODE  out  5  latched INSN[15:11]
OP_IMM  out  8  latched INSN[7:0]
OP_N_DST  out  3  latched INSN[10:8]
OP_WR  out  1  latched INSN_WR
SB_PEND  out  8  scoreboard, bit n = write to register n in flight

Behaviour:
- Everything changes only on the rising edge of CLK_RD.
- Reset: RESET=1 at an edge clears OP_VALID, OP_A, OP_B, OP_CODE, OP_IMM, OP_N_DST, OP_WR and SB_PEND to 0.
  - Reset mid-operation discards any held bundle and all pending bits.
  - INSN_READY is 0 while RESET=1.
- Source read (combinational):
  - src(n) = WB_REG_IN when WB_REG_WEN and WB_N_REG==n; otherwise REG_n.
  - Same-cycle write-back always wins over the register bus.
- Hazard (combinational, only when SB_EN=1):
  - clr(n) = WB_REG_WEN and WB_N_REG==n.
  - pend_eff(n) = SB_PEND[n] and not clr(n).
  - HAZ = pend_eff(INSN[10:8]) or pend_eff(INSN[7:5]).
  - The N_A check covers both RAW on A and WAW on the destination.
- INSN_READY = not RESET and not HAZ and (not OP_VALID or OP_READY).
  - It is derived from state and inputs; it does not depend on INSN_VALID.
- Accept when INSN_VALID and INSN_READY. On accept, at the edge:
  - OP_A <= src(INSN[10:8]); OP_B <= src(INSN[7:5]).
  - OP_CODE, OP_IMM, OP_N_DST and OP_WR load from INSN / INSN_WR.
  - OP_VALID <= 1.
- Otherwise, if OP_VALID and OP_READY: OP_VALID <= 0 and the data fields hold their values.
- A held bundle (OP_VALID=1, OP_READY=0) keeps every OP_* field stable until consumed. Throughput is 1 instruction/cycle when OP_READY stays high.
- Scoreboard next state: SB_PEND <= (SB_PEND and not clr) or set.
  - set = one-hot(INSN[10:8]) when accepting with INSN_WR=1.
  - When set and clr hit the same bit in the same cycle, set wins and the bit stays 1.
- A write-back to a register with no pending bit is legal and leaves SB_PEND unchanged.
- No latency beyond the one register stage: OP_VALID rises the cycle after accept.

Test Plan:
- Reset then issue INSN=0x1240 (N_A=2, N_B=2) with REG_2=0x1234, INSN_WR=0, OP_READY=1 -> next cycle OP_VALID=1, OP_A=OP_B=0x1234, OP_CODE=0x02, OP_IMM=0x40, SB_PEND=0x00.
- Forwarding: REG_3=0x0000 with WB_REG_WEN=1, WB_N_REG=3, WB_REG_IN=0xBEEF, INSN reads N_B=3 -> OP_B=0xBEEF.
- Scoreboard stall:
  - Accept a write to r5 -> SB_PEND=0x20.
  - Next instruction reads r5 -> INSN_READY=0 while SB_PEND[5]=1.
  - WB_REG_WEN=1 to r5 with 0x00AA -> INSN_READY=1 that cycle, OP_A=0x00AA, SB_PEND=0x00.
- Back-pressure: OP_READY=0 for 3 cycles with OP_VALID=1 and INSN_VALID=1 -> INSN_READY=0 and OP_* fields stable. Release -> bundles transfer back to back at 1/cycle.
- Set/clear collision: SB_PEND=0x04, accept INSN_WR=1 to r2 while WB retires r2 -> SB_PEND stays 0x04.
- Reset mid-operation: OP_VALID=1, SB_PEND=0xFF, assert RESET one cycle -> OP_VALID=0 and SB_PEND=0x00 after the edge, all OP_* = 0.
